// File: rtl/data_deframer.sv
// Receive-side deframer: pops bytes from a FWFT queue, parses 00/src/payload
// frames and emits 10-bit samples (or zero-extended DIN bytes) with valid/ready.
module data_deframer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_read,
  input  logic       em_read,
  output logic       pp_read,
  output logic [9:0] out_data,
  output logic [2:0] out_src,
  output logic       out_valid,
  input  logic       out_rdy,
  output logic       err_frame,
  output logic [7:0] err_cnt,
  output logic       synced
);

  typedef enum logic [2:0] {
    HUNT,
    EXPECT_ZERO,
    SRC,
    DATA_LO,
    DATA_HI,
    WAIT_OUT
  } state_t;

  localparam logic [2:0] SRC_DIN = 3'd1;

  state_t     state;
  logic [2:0] src_q;
  logic [7:0] lo_q;
  logic       take;
  logic       src_ok;
  logic       err_hit;

  // The head byte is stale while a pop is in flight, so takes are at most every other edge.
  always_comb begin
    take   = 1'b0;
    src_ok = 1'b0;
    take   = (state != WAIT_OUT) && !em_read && !pp_read;
    src_ok = (in_read >= 8'd1) && (in_read <= 8'd5);
  end

  always_comb begin
    err_hit = 1'b0;
    if (take) begin
      case (state)
        EXPECT_ZERO: err_hit = (in_read != 8'h00);
        SRC:         err_hit = !src_ok;
        DATA_HI:     err_hit = (in_read[7:2] != 6'd0);
        default:     err_hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      pp_read   <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
      err_frame <= 1'b0;
      err_cnt   <= '0;
      synced    <= 1'b0;
      src_q     <= '0;
      lo_q      <= '0;
    end else begin
      pp_read   <= take;
      err_frame <= err_hit;
      if (err_hit && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      if (take) begin
        case (state)
          HUNT: begin
            if (in_read == 8'h00) begin
              state  <= SRC;
              synced <= 1'b1;
            end
          end
          EXPECT_ZERO: begin
            if (in_read == 8'h00) begin
              state <= SRC;
            end else begin
              state  <= HUNT;
              synced <= 1'b0;
            end
          end
          SRC: begin
            if (src_ok) begin
              src_q <= in_read[2:0];
              state <= DATA_LO;
            end else if (in_read != 8'h00) begin
              state  <= HUNT;
              synced <= 1'b0;
            end
          end
          DATA_LO: begin
            if (src_q == SRC_DIN) begin
              out_data  <= {2'b00, in_read};
              out_src   <= src_q;
              out_valid <= 1'b1;
              state     <= WAIT_OUT;
            end else begin
              lo_q  <= in_read;
              state <= DATA_HI;
            end
          end
          DATA_HI: begin
            if (in_read[7:2] == 6'd0) begin
              out_data  <= {in_read[1:0], lo_q};
              out_src   <= src_q;
              out_valid <= 1'b1;
              state     <= WAIT_OUT;
            end else begin
              state  <= HUNT;
              synced <= 1'b0;
            end
          end
          default: state <= HUNT;
        endcase
      end else if ((state == WAIT_OUT) && out_rdy) begin
        out_valid <= 1'b0;
        state     <= EXPECT_ZERO;
      end
    end
  end

endmodule
